// File: rtl/control_unit.sv
// RV32I main + ALU decoder with sticky illegal-instruction flag (optional branch stats: CU_BRANCH_STATS_EN).
// Latency: decode is combinational (0 cycles); IllegalSeen/BranchTaken update on the rising clk edge.
// Backpressure: none; outputs always reflect the current Instr, Zero and Negative.
module control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic        Zero,
    input  logic        Negative,
    output logic        RegWrite,
    output logic        ALUSrc,
    output logic        MemWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  PCSrc,
    output logic [2:0]  ImmSrc,
    output logic [4:0]  ALUControl,
    output logic        IllegalInstr,
    output logic        IllegalSeen
`ifdef CU_BRANCH_STATS_EN
    ,
    output logic [31:0] BranchTaken
`endif
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_AND  = 5'b00010;
    localparam logic [4:0] ALU_OR   = 5'b00011;
    localparam logic [4:0] ALU_XOR  = 5'b00100;
    localparam logic [4:0] ALU_SLL  = 5'b00101;
    localparam logic [4:0] ALU_SRL  = 5'b00110;
    localparam logic [4:0] ALU_SRA  = 5'b00111;
    localparam logic [4:0] ALU_SLT  = 5'b01000;
    localparam logic [4:0] ALU_SLTU = 5'b01001;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_IMM = 2'b11;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_REL   = 2'b01;
    localparam logic [1:0] PC_ALU   = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic       mem_write;
        logic [1:0] result_src;
        logic [1:0] pc_src;
        logic [2:0] imm_src;
        logic [4:0] alu_ctrl;
    } ctrl_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    ctrl_t      ctrl;
    logic       illegal;
    logic       unused_instr_bits;

    assign opcode = Instr[6:0];
    assign funct3 = Instr[14:12];
    assign funct7 = Instr[31:25];
    assign unused_instr_bits = ^{Instr[24:15], Instr[11:7]};

    always_comb begin
        ctrl    = '0;
        illegal = 1'b0;
        case (opcode)
            OP_R: begin
                ctrl.reg_write = 1'b1;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000:  ctrl.alu_ctrl = ALU_ADD;
                        3'b001:  ctrl.alu_ctrl = ALU_SLL;
                        3'b010:  ctrl.alu_ctrl = ALU_SLT;
                        3'b011:  ctrl.alu_ctrl = ALU_SLTU;
                        3'b100:  ctrl.alu_ctrl = ALU_XOR;
                        3'b101:  ctrl.alu_ctrl = ALU_SRL;
                        3'b110:  ctrl.alu_ctrl = ALU_OR;
                        default: ctrl.alu_ctrl = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    ctrl.alu_ctrl = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    ctrl.alu_ctrl = ALU_SRA;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_I_ALU: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.imm_src   = IMM_I;
                // funct7 is immediate data except on the shift forms
                case (funct3)
                    3'b000: ctrl.alu_ctrl = ALU_ADD;
                    3'b001: begin
                        ctrl.alu_ctrl = ALU_SLL;
                        illegal       = (funct7 != F7_BASE);
                    end
                    3'b010: ctrl.alu_ctrl = ALU_SLT;
                    3'b011: ctrl.alu_ctrl = ALU_SLTU;
                    3'b100: ctrl.alu_ctrl = ALU_XOR;
                    3'b101: begin
                        if (funct7 == F7_BASE)     ctrl.alu_ctrl = ALU_SRL;
                        else if (funct7 == F7_ALT) ctrl.alu_ctrl = ALU_SRA;
                        else                       illegal       = 1'b1;
                    end
                    3'b110:  ctrl.alu_ctrl = ALU_OR;
                    default: ctrl.alu_ctrl = ALU_AND;
                endcase
            end
            OP_LOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.imm_src    = IMM_I;
                ctrl.alu_ctrl   = ALU_ADD;
                ctrl.result_src = RES_MEM;
                illegal         = (funct3 != 3'b010);
            end
            OP_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.imm_src   = IMM_S;
                ctrl.alu_ctrl  = ALU_ADD;
                illegal        = (funct3 != 3'b010);
            end
            OP_BRANCH: begin
                ctrl.imm_src = IMM_B;
                // Unsigned compares use SLTU so Zero means "not less than"
                case (funct3)
                    3'b000: begin
                        ctrl.alu_ctrl = ALU_SUB;
                        ctrl.pc_src   = Zero ? PC_REL : PC_PLUS4;
                    end
                    3'b001: begin
                        ctrl.alu_ctrl = ALU_SUB;
                        ctrl.pc_src   = !Zero ? PC_REL : PC_PLUS4;
                    end
                    3'b100: begin
                        ctrl.alu_ctrl = ALU_SUB;
                        ctrl.pc_src   = Negative ? PC_REL : PC_PLUS4;
                    end
                    3'b101: begin
                        ctrl.alu_ctrl = ALU_SUB;
                        ctrl.pc_src   = !Negative ? PC_REL : PC_PLUS4;
                    end
                    3'b110: begin
                        ctrl.alu_ctrl = ALU_SLTU;
                        ctrl.pc_src   = !Zero ? PC_REL : PC_PLUS4;
                    end
                    3'b111: begin
                        ctrl.alu_ctrl = ALU_SLTU;
                        ctrl.pc_src   = Zero ? PC_REL : PC_PLUS4;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_JAL: begin
                ctrl.reg_write  = 1'b1;
                ctrl.imm_src    = IMM_J;
                ctrl.result_src = RES_PC4;
                ctrl.pc_src     = PC_REL;
            end
            OP_JALR: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.imm_src    = IMM_I;
                ctrl.alu_ctrl   = ALU_ADD;
                ctrl.result_src = RES_PC4;
                ctrl.pc_src     = PC_ALU;
                illegal         = (funct3 != 3'b000);
            end
            OP_LUI: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.imm_src    = IMM_U;
                ctrl.result_src = RES_IMM;
            end
            default: illegal = 1'b1;
        endcase
    end

    // An illegal instruction must not write state or redirect the PC
    assign {RegWrite, ALUSrc, MemWrite, ResultSrc, PCSrc, ImmSrc, ALUControl} =
        illegal ? '0 : ctrl;
    assign IllegalInstr = illegal;

    logic illegal_seen_q, illegal_seen_d;

    always_comb begin
        illegal_seen_d = illegal_seen_q | illegal;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) illegal_seen_q <= 1'b0;
        else       illegal_seen_q <= illegal_seen_d;
    end

    assign IllegalSeen = illegal_seen_q;

`ifdef CU_BRANCH_STATS_EN
    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic        branch_taken;

    assign branch_taken = (opcode == OP_BRANCH) && (PCSrc == PC_REL);

    always_comb begin
        branch_cnt_d = branch_cnt_q;
        if (branch_taken) branch_cnt_d = branch_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) branch_cnt_q <= 32'd0;
        else       branch_cnt_q <= branch_cnt_d;
    end

    assign BranchTaken = branch_cnt_q;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: decode vectors, sticky illegal flag, optional branch counter.
module tb_control_unit;

    logic        clk;
    logic        reset;
    logic [31:0] Instr;
    logic        Zero;
    logic        Negative;
    logic        RegWrite;
    logic        ALUSrc;
    logic        MemWrite;
    logic [1:0]  ResultSrc;
    logic [1:0]  PCSrc;
    logic [2:0]  ImmSrc;
    logic [4:0]  ALUControl;
    logic        IllegalInstr;
    logic        IllegalSeen;
`ifdef CU_BRANCH_STATS_EN
    logic [31:0] BranchTaken;
`endif

    int checks = 0;
    int errors = 0;

    control_unit dut (
        .clk          (clk),
        .reset        (reset),
        .Instr        (Instr),
        .Zero         (Zero),
        .Negative     (Negative),
        .RegWrite     (RegWrite),
        .ALUSrc       (ALUSrc),
        .MemWrite     (MemWrite),
        .ResultSrc    (ResultSrc),
        .PCSrc        (PCSrc),
        .ImmSrc       (ImmSrc),
        .ALUControl   (ALUControl),
        .IllegalInstr (IllegalInstr),
        .IllegalSeen  (IllegalSeen)
`ifdef CU_BRANCH_STATS_EN
        ,
        .BranchTaken  (BranchTaken)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {RegWrite, ImmSrc, ALUSrc, ALUControl, MemWrite, ResultSrc, PCSrc, IllegalInstr}
    logic [15:0] obs_v;
    assign obs_v = {RegWrite, ImmSrc, ALUSrc, ALUControl, MemWrite, ResultSrc, PCSrc, IllegalInstr};

    function automatic logic [15:0] pk(input logic rw, input logic [2:0] imm, input logic as,
                                       input logic [4:0] alu, input logic mw, input logic [1:0] rs,
                                       input logic [1:0] pc, input logic ill);
        return {rw, imm, as, alu, mw, rs, pc, ill};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic [31:0] ins, input logic z, input logic n);
        @(negedge clk);
        Instr    = ins;
        Zero     = z;
        Negative = n;
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        Instr    = 32'h002081B3;
        Zero     = 1'b0;
        Negative = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_seen", {15'd0, IllegalSeen}, 16'd0);
        chk("decode_in_reset", obs_v, pk(1, 3'b000, 0, 5'b00000, 0, 2'b00, 2'b00, 0));
        @(negedge clk);
        reset = 1'b0;

        // legal decode
        apply(32'h002081B3, 0, 0); chk("add",   obs_v, pk(1, 3'b000, 0, 5'b00000, 0, 2'b00, 2'b00, 0));
        apply(32'h00508113, 0, 0); chk("addi",  obs_v, pk(1, 3'b000, 1, 5'b00000, 0, 2'b00, 2'b00, 0));
        apply(32'h402081B3, 0, 0); chk("sub",   obs_v, pk(1, 3'b000, 0, 5'b00001, 0, 2'b00, 2'b00, 0));
        apply(32'h4020D1B3, 0, 0); chk("sra",   obs_v, pk(1, 3'b000, 0, 5'b00111, 0, 2'b00, 2'b00, 0));
        apply(32'h0020C1B3, 0, 0); chk("xor",   obs_v, pk(1, 3'b000, 0, 5'b00100, 0, 2'b00, 2'b00, 0));
        apply(32'h0020A1B3, 0, 0); chk("slt",   obs_v, pk(1, 3'b000, 0, 5'b01000, 0, 2'b00, 2'b00, 0));
        apply(32'h0020F1B3, 0, 0); chk("and",   obs_v, pk(1, 3'b000, 0, 5'b00010, 0, 2'b00, 2'b00, 0));
        apply(32'h4030D093, 0, 0); chk("srai",  obs_v, pk(1, 3'b000, 1, 5'b00111, 0, 2'b00, 2'b00, 0));
        apply(32'h0030B093, 0, 0); chk("sltiu", obs_v, pk(1, 3'b000, 1, 5'b01001, 0, 2'b00, 2'b00, 0));
        apply(32'h0030E093, 0, 0); chk("ori",   obs_v, pk(1, 3'b000, 1, 5'b00011, 0, 2'b00, 2'b00, 0));
        apply(32'h0050A103, 0, 0); chk("lw",    obs_v, pk(1, 3'b000, 1, 5'b00000, 0, 2'b01, 2'b00, 0));
        apply(32'h0020A1A3, 0, 0); chk("sw",    obs_v, pk(0, 3'b001, 1, 5'b00000, 1, 2'b00, 2'b00, 0));
        apply(32'h002081E3, 1, 0); chk("beq_t", obs_v, pk(0, 3'b010, 0, 5'b00001, 0, 2'b00, 2'b01, 0));
        apply(32'h002081E3, 0, 0); chk("beq_n", obs_v, pk(0, 3'b010, 0, 5'b00001, 0, 2'b00, 2'b00, 0));
        apply(32'h002091E3, 0, 0); chk("bne_t", obs_v, pk(0, 3'b010, 0, 5'b00001, 0, 2'b00, 2'b01, 0));
        apply(32'h002091E3, 1, 0); chk("bne_n", obs_v, pk(0, 3'b010, 0, 5'b00001, 0, 2'b00, 2'b00, 0));
        apply(32'h0020C1E3, 0, 1); chk("blt_t", obs_v, pk(0, 3'b010, 0, 5'b00001, 0, 2'b00, 2'b01, 0));
        apply(32'h0020D1E3, 0, 1); chk("bge_n", obs_v, pk(0, 3'b010, 0, 5'b00001, 0, 2'b00, 2'b00, 0));
        apply(32'h0020D1E3, 0, 0); chk("bge_t", obs_v, pk(0, 3'b010, 0, 5'b00001, 0, 2'b00, 2'b01, 0));
        apply(32'h0020E1E3, 0, 0); chk("bltu_t", obs_v, pk(0, 3'b010, 0, 5'b01001, 0, 2'b00, 2'b01, 0));
        apply(32'h0020F1E3, 0, 0); chk("bgeu_n", obs_v, pk(0, 3'b010, 0, 5'b01001, 0, 2'b00, 2'b00, 0));
        apply(32'h0020F1E3, 1, 0); chk("bgeu_t", obs_v, pk(0, 3'b010, 0, 5'b01001, 0, 2'b00, 2'b01, 0));
        apply(32'h000010EF, 0, 0); chk("jal",   obs_v, pk(1, 3'b011, 0, 5'b00000, 0, 2'b10, 2'b01, 0));
        apply(32'h00508167, 0, 0); chk("jalr",  obs_v, pk(1, 3'b000, 1, 5'b00000, 0, 2'b10, 2'b10, 0));
        apply(32'h000010B7, 0, 0); chk("lui",   obs_v, pk(1, 3'b100, 1, 5'b00000, 0, 2'b11, 2'b00, 0));
        apply(32'h002081B3, 0, 0);
        chk("seen_legal", {15'd0, IllegalSeen}, 16'd0);

        // illegal decode
        apply(32'h00001097, 0, 0); chk("auipc",   obs_v, 16'h0001);
        chk("seen_before_edge", {15'd0, IllegalSeen}, 16'd0);
        @(posedge clk); #1;
        chk("seen_after_edge", {15'd0, IllegalSeen}, 16'd1);
        apply(32'h402091B3, 0, 0); chk("r_bad_f7", obs_v, 16'h0001);
        apply(32'h40309093, 0, 0); chk("slli_bad", obs_v, 16'h0001);
        apply(32'h0020A1E3, 1, 0); chk("br_f3_010", obs_v, 16'h0001);
        apply(32'h0050B103, 0, 0); chk("ld_f3_011", obs_v, 16'h0001);
        apply(32'h00509167, 0, 0); chk("jalr_f3", obs_v, 16'h0001);
        apply(32'h0000000F, 0, 0); chk("fence",   obs_v, 16'h0001);
        apply(32'h00000073, 0, 0); chk("ecall",   obs_v, 16'h0001);
        apply(32'h002081B3, 0, 0);
        repeat (3) @(posedge clk); #1;
        chk("seen_sticky", {15'd0, IllegalSeen}, 16'd1);

        // async reset clears without an edge
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("seen_async_clr", {15'd0, IllegalSeen}, 16'd0);

        // reset beats a simultaneous illegal instruction
        Instr = 32'h00001097;
        @(posedge clk); #1;
        chk("seen_reset_wins", {15'd0, IllegalSeen}, 16'd0);
        @(negedge clk);
        Instr = 32'h002081B3;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("seen_after_rst", {15'd0, IllegalSeen}, 16'd0);

`ifdef CU_BRANCH_STATS_EN
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk32("bt_reset", BranchTaken, 32'd0);
        reset = 1'b0;
        apply(32'h002081E3, 1, 0);
        apply(32'h002081E3, 1, 0);
        apply(32'h002081E3, 0, 0);
        apply(32'h002081E3, 1, 0);
        apply(32'h000010EF, 0, 0);
        apply(32'h002081B3, 0, 0);
        chk32("bt_count", BranchTaken, 32'd3);
        reset = 1'b1;
        #1;
        chk32("bt_clear", BranchTaken, 32'd0);
        reset = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
